// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - refill FSM state encoding, address-split constants and tag-width helper
package cache_pkg;

  typedef enum logic [2:0] {
    RS_IDLE      = 3'd0,
    RS_VICTIM    = 3'd1,
    RS_WB        = 3'd2,
    RS_FILL_REQ  = 3'd3,
    RS_FILL_WAIT = 3'd4,
    RS_COMMIT    = 3'd5
  } refill_state_t;

  // Byte offset inside a 32-bit word, plus the default geometry (4 words/line, 64 sets).
  localparam int OFFSET_BITS = 2;
  localparam int WORD_BITS   = 2;
  localparam int SET_BITS    = 6;

  function automatic int tag_width(input int addr_width, input int set_count, input int words_per_line);
    return addr_width - $clog2(set_count) - $clog2(words_per_line) - OFFSET_BITS;
  endfunction

endpackage

// File: rtl/refill_word_counter.sv
// rtl/refill_word_counter.sv - word index within the line being written back or filled
module refill_word_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  // Wraps to zero on the increment after the last word, so no explicit clear is needed there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign last = &count;

endmodule

// File: rtl/cache_refill_controller.sv
// rtl/cache_refill_controller.sv - cache line refill sequencer: victim select, writeback, fill, commit
// REFILL_WRITEBACK_EN adds the dirty-victim writeback path; without it the cache is write-through.
module cache_refill_controller
  import cache_pkg::*;
#(
  parameter int  WAY_COUNT      = 2,
  parameter int  SET_COUNT      = 64,
  parameter int  WORDS_PER_LINE = 4,
  parameter int  ADDR_WIDTH     = 32,
  localparam int WAY_W          = $clog2(WAY_COUNT),
  localparam int SET_W          = $clog2(SET_COUNT),
  localparam int WORD_W         = $clog2(WORDS_PER_LINE),
  localparam int TAG_WIDTH      = tag_width(ADDR_WIDTH, SET_COUNT, WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  done,
  output logic [SET_W-1:0]      rp_set,
  input  logic [WAY_W-1:0]      rp_way,
  input  logic                  rp_ready,
  output logic                  rp_taken,
  input  logic [TAG_WIDTH-1:0]  victim_tag,
  input  logic                  victim_dirty,
  output logic [SET_W-1:0]      line_set,
  output logic [WAY_W-1:0]      line_way,
  output logic [WORD_W-1:0]     line_word,
  input  logic [31:0]           line_rdata,
  output logic                  line_we,
  output logic [31:0]           line_wdata,
  output logic                  tag_we,
  output logic [TAG_WIDTH-1:0]  tag_wdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  localparam logic [2:0] IDLE      = RS_IDLE;
  localparam logic [2:0] VICTIM    = RS_VICTIM;
  localparam logic [2:0] FILL_REQ  = RS_FILL_REQ;
  localparam logic [2:0] FILL_WAIT = RS_FILL_WAIT;
  localparam logic [2:0] COMMIT    = RS_COMMIT;
`ifdef REFILL_WRITEBACK_EN
  localparam logic [2:0] WB        = RS_WB;
`endif

  logic [2:0]            state;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [SET_W-1:0]      set_q;
  logic [WORD_W-1:0]     offset_q;
  logic [WAY_W-1:0]      way_q;
  logic [WORD_W-1:0]     word;
  logic                  word_last;
  logic                  word_inc;
  logic                  rp_grant;
  logic                  req_accept;
  logic                  fill_beat;
  logic [ADDR_WIDTH-1:0] fill_addr;

  assign rp_grant   = (state == VICTIM) && rp_ready;
  assign req_accept = mem_req_valid && mem_req_ready;
  // Responses are only meaningful while a fill read is outstanding.
  assign fill_beat  = (state == FILL_WAIT) && mem_rvalid;
  assign fill_addr  = {tag_q, set_q, word, {OFFSET_BITS{1'b0}}};

  refill_word_counter #(
    .WIDTH(WORD_W)
  ) u_word_counter (
    .clk   (clk),
    .reset (reset),
    .clear (rp_grant),
    .inc   (word_inc),
    .count (word),
    .last  (word_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tag_q    <= '0;
      set_q    <= '0;
      offset_q <= '0;
      way_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_valid) begin
            tag_q    <= miss_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
            set_q    <= miss_addr[OFFSET_BITS+WORD_W +: SET_W];
            offset_q <= miss_addr[OFFSET_BITS +: WORD_W];
            state    <= VICTIM;
          end
        end
        VICTIM: begin
          if (rp_ready) begin
            way_q <= rp_way;
`ifdef REFILL_WRITEBACK_EN
            state <= victim_dirty ? WB : FILL_REQ;
`else
            state <= FILL_REQ;
`endif
          end
        end
`ifdef REFILL_WRITEBACK_EN
        WB: begin
          if (req_accept && word_last) state <= FILL_REQ;
        end
`endif
        FILL_REQ: begin
          if (req_accept) state <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (mem_rvalid) state <= word_last ? COMMIT : FILL_REQ;
        end
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REFILL_WRITEBACK_EN
  logic [TAG_WIDTH-1:0] vtag_q;
  logic                 wb_active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vtag_q <= '0;
    end else if (rp_grant) begin
      vtag_q <= victim_tag;
    end
  end

  assign wb_active     = (state == WB);
  assign word_inc      = fill_beat || (wb_active && req_accept);
  assign mem_req_valid = wb_active || (state == FILL_REQ);
  assign mem_req_we    = wb_active;
  // The data-array read is indexed by the held counter, so wdata stays stable while stalled.
  assign mem_wdata     = wb_active ? line_rdata : 32'd0;

  always_comb begin
    mem_req_addr = '0;
    if (wb_active) begin
      mem_req_addr = {vtag_q, set_q, word, {OFFSET_BITS{1'b0}}};
    end else if (state == FILL_REQ) begin
      mem_req_addr = fill_addr;
    end
  end
`else
  logic unused_wb;

  assign unused_wb     = ^{victim_tag, victim_dirty, line_rdata};
  assign word_inc      = fill_beat;
  assign mem_req_valid = (state == FILL_REQ);
  assign mem_req_we    = 1'b0;
  assign mem_wdata     = 32'd0;
  assign mem_req_addr  = (state == FILL_REQ) ? fill_addr : '0;
`endif

  logic unused_fields;
  assign unused_fields = ^{offset_q, miss_addr[OFFSET_BITS-1:0]};

  assign miss_ready = (state == IDLE);
  assign rp_set     = set_q;
  assign line_set   = set_q;
  assign line_way   = way_q;
  assign line_word  = word;
  assign line_we    = fill_beat;
  assign line_wdata = fill_beat ? mem_rdata : 32'd0;
  assign done       = (state == COMMIT);
  assign rp_taken   = (state == COMMIT);
  assign tag_we     = (state == COMMIT);
  assign tag_wdata  = (state == COMMIT) ? tag_q : '0;

endmodule

// File: tb/tb_cache_refill_controller.sv
// tb/tb_cache_refill_controller.sv - scoreboard bench for cache_refill_controller
module tb_cache_refill_controller;

`ifdef REFILL_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        miss_valid;
  logic        miss_ready;
  logic [31:0] miss_addr;
  logic        done;
  logic [5:0]  rp_set;
  logic [0:0]  rp_way;
  logic        rp_ready;
  logic        rp_taken;
  logic [21:0] victim_tag;
  logic        victim_dirty;
  logic [5:0]  line_set;
  logic [0:0]  line_way;
  logic [1:0]  line_word;
  logic [31:0] line_rdata;
  logic        line_we;
  logic [31:0] line_wdata;
  logic        tag_we;
  logic [21:0] tag_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  cache_refill_controller dut (
    .clk           (clk),
    .reset         (reset),
    .miss_valid    (miss_valid),
    .miss_ready    (miss_ready),
    .miss_addr     (miss_addr),
    .done          (done),
    .rp_set        (rp_set),
    .rp_way        (rp_way),
    .rp_ready      (rp_ready),
    .rp_taken      (rp_taken),
    .victim_tag    (victim_tag),
    .victim_dirty  (victim_dirty),
    .line_set      (line_set),
    .line_way      (line_way),
    .line_word     (line_word),
    .line_rdata    (line_rdata),
    .line_we       (line_we),
    .line_wdata    (line_wdata),
    .tag_we        (tag_we),
    .tag_wdata     (tag_wdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [1:0]  word;
    logic [31:0] data;
    logic        way;
    logic [5:0]  set;
  } line_t;

  typedef struct {
    int          cyc;
    logic [21:0] tag;
  } commit_t;

  req_t    req_q[$];
  line_t   line_q[$];
  commit_t commit_q[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          spurious = 0;
  int          stall_left = 0;
  bit          held_valid = 0;
  logic [31:0] held_addr;
  logic [31:0] held_data;
  logic        outs_any;

  function automatic logic [31:0] arr_word(input logic [5:0] s, input logic w, input logic [1:0] k);
    return {8'hA5, 2'b00, s, 7'd0, w, 6'd0, k};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  assign line_rdata = arr_word(line_set, line_way[0], line_word);
  assign outs_any = |{mem_req_valid, mem_req_we, mem_req_addr, mem_wdata, done, rp_set, rp_taken,
                      line_set, line_way, line_word, line_we, line_wdata, tag_we, tag_wdata};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Memory model: zero-wait unless stalled, read data one cycle after acceptance.
  initial begin
    req_t r;
    logic resp_due;
    logic [31:0] resp_data;
    resp_due = 1'b0;
    resp_data = 32'd0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'd0;
    mem_req_ready = 1'b1;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata = 32'd0;
      if (resp_due) begin
        mem_rvalid = 1'b1;
        mem_rdata = resp_data;
        resp_due = 1'b0;
      end else if (spurious && (miss_ready || (mem_req_valid && mem_req_we))) begin
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      mem_req_ready = 1'b1;
      if (mem_req_valid && mem_req_addr[3:2] == 2'd2 && stall_left > 0) begin
        if (!held_valid) begin
          held_valid = 1'b1;
          held_addr = mem_req_addr;
          held_data = mem_wdata;
        end else begin
          chk("stall_addr_hold", mem_req_addr, held_addr);
          chk("stall_data_hold", mem_wdata, held_data);
        end
        stall_left--;
        mem_req_ready = 1'b0;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (held_valid) begin
          chk("stall_addr_accept", mem_req_addr, held_addr);
          held_valid = 1'b0;
        end
        if (req_q.size() == 0) begin
          chk("req_unexpected", mem_req_addr, 32'hFFFF_FFFF);
        end else begin
          r = req_q.pop_front();
          chk("req_we", mem_req_we, r.we);
          chk("req_addr", mem_req_addr, r.addr);
          if (r.we) chk("req_wdata", mem_wdata, r.data);
        end
        if (!mem_req_we) begin
          resp_due = 1'b1;
          resp_data = mem_word(mem_req_addr);
        end
      end
    end
  end

  // Output monitor: line writes and commits are popped from their scoreboards.
  initial begin
    line_t l;
    commit_t c;
    forever begin
      @(negedge clk);
      #2;
      if (line_we) begin
        if (line_q.size() == 0) begin
          chk("line_we_unexpected", line_wdata, 32'hFFFF_FFFF);
        end else begin
          l = line_q.pop_front();
          chk("line_word", line_word, l.word);
          chk("line_wdata", line_wdata, l.data);
          chk("line_way", line_way, l.way);
          chk("line_set", line_set, l.set);
        end
      end
      if (done || tag_we || rp_taken) begin
        if (commit_q.size() == 0) begin
          chk("commit_unexpected", {done, tag_we, rp_taken}, 3'b000);
        end else begin
          c = commit_q.pop_front();
          chk("commit_cycle", cyc, c.cyc);
          chk("commit_tag", tag_wdata, c.tag);
          chk("commit_strobes", {done, tag_we, rp_taken}, 3'b111);
        end
      end
    end
  end

  task automatic do_miss(input logic [31:0] a, input logic way, input logic [21:0] vt,
                         input logic d, input int rpd, input int stall);
    logic [5:0]  s;
    logic [21:0] t;
    logic [31:0] fa;
    logic        wb;
    bit          got;
    s = a[9:4];
    t = a[31:10];
    wb = WB_EN && d;
    @(negedge clk);
    chk("miss_ready_idle", miss_ready, 1);
    rp_way = way;
    victim_tag = vt;
    victim_dirty = d;
    stall_left = stall;
    if (wb) begin
      for (int k = 0; k < 4; k++)
        req_q.push_back('{1'b1, {vt, s, 2'(k), 2'b00}, arr_word(s, way, 2'(k))});
    end
    for (int k = 0; k < 4; k++) begin
      fa = {t, s, 2'(k), 2'b00};
      req_q.push_back('{1'b0, fa, 32'd0});
      line_q.push_back('{2'(k), mem_word(fa), way, s});
    end
    commit_q.push_back('{cyc + 10 + (wb ? 4 : 0) + rpd + stall, t});
    miss_addr = a;
    miss_valid = 1'b1;
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    if (rpd > 0) begin
      rp_ready = 1'b0;
      for (int i = 0; i < rpd; i++) begin
        @(negedge clk);
        #2;
        chk("victim_no_req", mem_req_valid, 0);
        chk("victim_rp_set", rp_set, s);
      end
      @(posedge clk);
      #1;
      rp_ready = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      #3;
      got = (commit_q.size() == 0);
    end
    if (!got) begin
      chk("commit_timeout", 0, 1);
      commit_q.delete();
      req_q.delete();
      line_q.delete();
    end else begin
      @(negedge clk);
      #3;
      chk("miss_ready_after_commit", miss_ready, 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    miss_valid = 1'b0;
    miss_addr = 32'd0;
    rp_way = 1'b0;
    rp_ready = 1'b1;
    victim_tag = 22'd0;
    victim_dirty = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #3;
    chk("reset_miss_ready", miss_ready, 1);
    chk("reset_outputs_zero", outs_any, 0);
    reset = 1'b0;

    spurious = 1'b1;
    repeat (3) @(posedge clk);
    do_miss(32'h0000_1234, 1'b1, 22'h00003, 1'b0, 0, 0);
    do_miss(32'h0000_5678, 1'b0, 22'h000AB, 1'b1, 0, 0);
    spurious = 1'b0;
    do_miss(32'hCAFE_0040, 1'b1, 22'h00155, 1'b0, 0, 3);
    do_miss(32'h8000_03F0, 1'b0, 22'h0002A, 1'b1, 2, 0);

    // Reset while waiting for the word-1 fill response.
    @(negedge clk);
    rp_way = 1'b1;
    victim_tag = 22'h7;
    victim_dirty = 1'b0;
    for (int k = 0; k < 2; k++)
      req_q.push_back('{1'b0, {22'h0A, 6'h28, 2'(k), 2'b00}, 32'd0});
    line_q.push_back('{2'd0, mem_word({22'h0A, 6'h28, 2'd0, 2'b00}), 1'b1, 6'h28});
    miss_addr = 32'h0000_2A80;
    miss_valid = 1'b1;
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    reset = 1'b1;
    #2;
    chk("midrst_miss_ready", miss_ready, 1);
    chk("midrst_outputs_zero", outs_any, 0);
    chk("midrst_req_drained", req_q.size(), 0);
    chk("midrst_line_drained", line_q.size(), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    do_miss(32'h0000_1234, 1'b0, 22'h00001, 1'b0, 0, 0);

    chk("final_req_drained", req_q.size(), 0);
    chk("final_line_drained", line_q.size(), 0);
    chk("final_commit_drained", commit_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
